// File: rtl/n64adv2_ctrl_keyevents_if.sv
// Bus between the controller sniffer/menu logic and the key-event generator.
// The generator is the slave: it consumes polls and acks, and drives key state and events.
interface n64adv2_ctrl_keyevents_if;
    logic [31:0] ctrl_data_i;
    logic        ctrl_data_valid_i;
    logic        ctrl_detected_i;
    logic [13:0] key_held_o;
    logic [13:0] key_evt_o;
    logic        key_evt_valid_o;
    logic        key_evt_ack_i;
    logic        key_evt_ovf_o;

    modport master (
        output ctrl_data_i, ctrl_data_valid_i, ctrl_detected_i, key_evt_ack_i,
        input  key_held_o, key_evt_o, key_evt_valid_o, key_evt_ovf_o
    );

    modport slave (
        input  ctrl_data_i, ctrl_data_valid_i, ctrl_detected_i, key_evt_ack_i,
        output key_held_o, key_evt_o, key_evt_valid_o, key_evt_ovf_o
    );
endinterface

// File: rtl/n64adv2_ctrl_keyevents.sv
// Turns sniffed N64 controller polls into 14 virtual key levels plus press/auto-repeat
// events, delivered through a sticky valid/ack handshake with an overflow flag.
module n64adv2_ctrl_keyevents #(
    parameter logic [7:0] REPEAT_DELAY = 8'd16,
    parameter logic [7:0] REPEAT_RATE  = 8'd4,
    parameter logic [7:0] STICK_TH     = 8'd40,
    parameter logic [7:0] STICK_HYST   = 8'd8
) (
    input logic                     CTRL_CLK_i,
    input logic                     CTRL_RST_i,
    n64adv2_ctrl_keyevents_if.slave kev_if
);

    typedef enum logic [1:0] {
        AX_CENTER = 2'd0,
        AX_POS    = 2'd1,
        AX_NEG    = 2'd2
    } axis_e;

    logic        run_q;
    logic        s1_vld_q;
    logic [31:0] s1_data_q;
    axis_e       x_q, x_d, y_q, y_d;
    logic [13:0] held_q, held_d;
    logic [7:0]  rpt_q, rpt_d;
    logic [3:0]  rpt_evt_s;
    logic [13:0] poll_evt_s;
    logic [13:0] evt_q, evt_d;
    logic        evt_vld_q, evt_vld_d;
    logic        ovf_q, ovf_d;
    logic        ack_s;
    logic        unused_s;

    // Axis bytes arrive MSB first, so the lowest wire bit is the sign bit.
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    function automatic axis_e axis_next(input axis_e cur, input logic [7:0] raw);
        logic signed [8:0] v, th, rel;
        axis_e nxt;
        v   = $signed({raw[7], raw});
        th  = $signed({1'b0, STICK_TH});
        rel = $signed({1'b0, STICK_TH - STICK_HYST});
        nxt = cur;
        case (cur)
            AX_CENTER: begin
                if (v >= th)       nxt = AX_POS;
                else if (v <= -th) nxt = AX_NEG;
                else               nxt = AX_CENTER;
            end
            AX_POS: begin
                if (v <= -th)      nxt = AX_NEG;
                else if (v < rel)  nxt = AX_CENTER;
                else               nxt = AX_POS;
            end
            AX_NEG: begin
                if (v >= th)       nxt = AX_POS;
                else if (v > -rel) nxt = AX_CENTER;
                else               nxt = AX_NEG;
            end
            default: nxt = AX_CENTER;
        endcase
        return nxt;
    endfunction

    // Blocks strobes on the first edge after reset release
    always_ff @(posedge CTRL_CLK_i or posedge CTRL_RST_i) begin
        if (CTRL_RST_i) run_q <= 1'b0;
        else            run_q <= 1'b1;
    end

    // Stage 1: capture the poll word
    always_ff @(posedge CTRL_CLK_i or posedge CTRL_RST_i) begin
        if (CTRL_RST_i) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= 32'd0;
        end else begin
            s1_vld_q <= kev_if.ctrl_data_valid_i & kev_if.ctrl_detected_i & run_q;
            if (kev_if.ctrl_data_valid_i) s1_data_q <= kev_if.ctrl_data_i;
        end
    end

    // Stage 2 next state: axis FSMs, key levels, repeat counter, poll event vector
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        held_d     = held_q;
        rpt_d      = rpt_q;
        rpt_evt_s  = 4'd0;
        poll_evt_s = 14'd0;
        if (!kev_if.ctrl_detected_i) begin
            x_d    = AX_CENTER;
            y_d    = AX_CENTER;
            held_d = 14'd0;
            rpt_d  = 8'd0;
        end else if (s1_vld_q) begin
            if (s1_data_q[8]) begin
                x_d = AX_CENTER;
                y_d = AX_CENTER;
            end else begin
                x_d = axis_next(x_q, rev8(s1_data_q[23:16]));
                y_d = axis_next(y_q, rev8(s1_data_q[31:24]));
            end
            held_d[3:0]  = s1_data_q[3:0];
            held_d[4]    = s1_data_q[4] | (y_d == AX_POS);
            held_d[5]    = s1_data_q[5] | (y_d == AX_NEG);
            held_d[6]    = s1_data_q[6] | (x_d == AX_NEG);
            held_d[7]    = s1_data_q[7] | (x_d == AX_POS);
            held_d[13:8] = s1_data_q[15:10];
            if ((held_d[7:4] == 4'd0) || (held_d[7:4] != held_q[7:4])) begin
                rpt_d = 8'd0;
            end else if ((rpt_q + 8'd1) == REPEAT_DELAY) begin
                rpt_d     = REPEAT_DELAY - REPEAT_RATE;
                rpt_evt_s = held_d[7:4];
            end else begin
                rpt_d = rpt_q + 8'd1;
            end
            poll_evt_s = (held_d & ~held_q) | {6'd0, rpt_evt_s, 4'd0};
        end else begin
            held_d = held_q;
        end
    end

    // Event handshake: merge new events, clear on ack, flag merges into unacked events
    always_comb begin
        ack_s     = kev_if.key_evt_ack_i & evt_vld_q;
        evt_d     = evt_q;
        evt_vld_d = evt_vld_q;
        ovf_d     = ovf_q;
        if (poll_evt_s != 14'd0) begin
            evt_vld_d = 1'b1;
            if (ack_s) begin
                evt_d = poll_evt_s;
            end else begin
                evt_d = evt_q | poll_evt_s;
                ovf_d = ovf_q | evt_vld_q;
            end
        end else if (ack_s) begin
            evt_d     = 14'd0;
            evt_vld_d = 1'b0;
        end else begin
            evt_d = evt_q;
        end
    end

    // Stage 2 and handshake state registers
    always_ff @(posedge CTRL_CLK_i or posedge CTRL_RST_i) begin
        if (CTRL_RST_i) begin
            x_q       <= AX_CENTER;
            y_q       <= AX_CENTER;
            held_q    <= 14'd0;
            rpt_q     <= 8'd0;
            evt_q     <= 14'd0;
            evt_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            held_q    <= held_d;
            rpt_q     <= rpt_d;
            evt_q     <= evt_d;
            evt_vld_q <= evt_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign kev_if.key_held_o      = held_q;
    assign kev_if.key_evt_o       = evt_q;
    assign kev_if.key_evt_valid_o = evt_vld_q;
    assign kev_if.key_evt_ovf_o   = ovf_q;
    assign unused_s               = s1_data_q[9];

endmodule
